load_split_merge: RTL and testbench

Sequential load-data unit between the LSU and the data-bus master port. It accepts one load request at a time and issues one aligned bus read, or two when the access crosses a DATA_WIDTH boundary. It then merges the returned beats, shifts the addressed bytes down to bit 0, and zero- or sign-extends the result before returning it through a valid/ready response channel.

---
 rtl/load_split_pkg.sv | 23 ++
 rtl/load_merge_extend.sv | 57 +++++
 rtl/load_split_merge.sv | 185 ++++++++++++++++++
 tb/tb_load_split_merge.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_split_pkg.sv
// Shared encodings for the load split/merge unit: access sizes, FSM states and
// the beat-offset width helper.
package load_split_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_REQ  = 3'd1,
    ST_LO_WAIT = 3'd2,
    ST_HI_REQ  = 3'd3,
    ST_HI_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  function automatic int beat_off_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/load_merge_extend.sv
// Combinational merge of the low/high beats: byte-shift the addressed data down
// to bit 0, then zero- or sign-extend it to the full result width.
module load_merge_extend
  import load_split_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HAS_SIGN   = 1
) (
  input  logic [DATA_WIDTH-1:0]                     lo,
  input  logic [DATA_WIDTH-1:0]                     hi,
  input  logic [beat_off_width(DATA_WIDTH)-1:0]     off,
  input  logic [1:0]                                size,
  input  logic                                      sign,
  output logic [DATA_WIDTH-1:0]                     data
);

  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] mask_s;
  logic                  sbit_s;
  logic                  full_s;
  logic                  ext_s;

  assign shifted_s = DATA_WIDTH'({hi, lo} >> {off, 3'b000});

  // Select the kept-bit mask and sign-bit position for the access size
  always_comb begin
    mask_s = {DATA_WIDTH{1'b1}};
    sbit_s = shifted_s[DATA_WIDTH-1];
    full_s = 1'b1;
    case (size)
      SZ_BYTE: begin
        mask_s = DATA_WIDTH'(8'hFF);
        sbit_s = shifted_s[7];
        full_s = 1'b0;
      end
      SZ_HALF: begin
        mask_s = DATA_WIDTH'(16'hFFFF);
        sbit_s = shifted_s[15];
        full_s = 1'b0;
      end
      SZ_WORD: begin
        mask_s = DATA_WIDTH'(32'hFFFF_FFFF);
        sbit_s = shifted_s[31];
        full_s = (DATA_WIDTH == 32);
      end
      default: begin
        mask_s = {DATA_WIDTH{1'b1}};
        sbit_s = shifted_s[DATA_WIDTH-1];
        full_s = 1'b1;
      end
    endcase
  end

  assign ext_s = (HAS_SIGN != 0) && sign && !full_s && sbit_s;
  assign data  = (shifted_s & mask_s) | (ext_s ? ~mask_s : {DATA_WIDTH{1'b0}});

endmodule

// File: rtl/load_split_merge.sv
// Load-data unit: one aligned bus read per request (two when the access crosses
// a beat boundary), merged and extended into a registered response.
module load_split_merge
  import load_split_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int HAS_SIGN    = 1,
  parameter int ALLOW_SPLIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rsp_data,
  input  logic                  bus_rsp_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_split
);

  localparam int OFF_W      = beat_off_width(DATA_WIDTH);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("load_split_merge: DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  state_e                state_r;
  logic [OFF_W-1:0]      off_r;
  logic [1:0]            size_r;
  logic                  sign_r;
  logic                  cross_r;
  logic [DATA_WIDTH-1:0] lo_buf_r;
  logic                  bus_req_valid_r;
  logic [ADDR_WIDTH-1:0] bus_req_addr_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic                  rsp_err_r;
  logic                  rsp_split_r;

  logic [OFF_W-1:0]      req_off_s;
  logic [4:0]            req_end_s;
  logic                  req_cross_s;
  logic                  req_illegal_s;
  logic [ADDR_WIDTH-1:0] req_base_s;
  logic [DATA_WIDTH-1:0] mrg_lo_s;
  logic [DATA_WIDTH-1:0] merged_s;

  assign req_off_s     = req_addr[OFF_W-1:0];
  assign req_end_s     = 5'(req_off_s) + (5'd1 << req_size);
  assign req_cross_s   = req_end_s > 5'(BEAT_BYTES);
  assign req_illegal_s = ((req_size == SZ_DOUBLE) && (DATA_WIDTH == 32)) ||
                         (req_cross_s && (ALLOW_SPLIT == 0));
  assign req_base_s    = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // The low beat comes straight off the bus when the access needs only one beat
  assign mrg_lo_s = (state_r == ST_LO_WAIT) ? bus_rsp_data : lo_buf_r;

  load_merge_extend #(
    .DATA_WIDTH (DATA_WIDTH),
    .HAS_SIGN   (HAS_SIGN)
  ) u_merge (
    .lo   (mrg_lo_s),
    .hi   (bus_rsp_data),
    .off  (off_r),
    .size (size_r),
    .sign (sign_r),
    .data (merged_s)
  );

  // Request sequencing FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      off_r           <= {OFF_W{1'b0}};
      size_r          <= 2'd0;
      sign_r          <= 1'b0;
      cross_r         <= 1'b0;
      lo_buf_r        <= {DATA_WIDTH{1'b0}};
      bus_req_valid_r <= 1'b0;
      bus_req_addr_r  <= {ADDR_WIDTH{1'b0}};
      rsp_valid_r     <= 1'b0;
      rsp_data_r      <= {DATA_WIDTH{1'b0}};
      rsp_err_r       <= 1'b0;
      rsp_split_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            off_r   <= req_off_s;
            size_r  <= req_size;
            sign_r  <= req_sign;
            cross_r <= req_cross_s;
            if (req_illegal_s) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= {DATA_WIDTH{1'b0}};
              rsp_err_r   <= 1'b1;
              rsp_split_r <= 1'b0;
            end else begin
              state_r         <= ST_LO_REQ;
              bus_req_valid_r <= 1'b1;
              bus_req_addr_r  <= req_base_s;
            end
          end
        end
        ST_LO_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid_r <= 1'b0;
            state_r         <= ST_LO_WAIT;
          end
        end
        ST_LO_WAIT: begin
          if (bus_rsp_valid) begin
            lo_buf_r <= bus_rsp_data;
            if (bus_rsp_err) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= {DATA_WIDTH{1'b0}};
              rsp_err_r   <= 1'b1;
              rsp_split_r <= 1'b0;
            end else if (cross_r) begin
              state_r         <= ST_HI_REQ;
              bus_req_valid_r <= 1'b1;
              bus_req_addr_r  <= bus_req_addr_r + ADDR_WIDTH'(BEAT_BYTES);
            end else begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= merged_s;
              rsp_err_r   <= 1'b0;
              rsp_split_r <= 1'b0;
            end
          end
        end
        ST_HI_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid_r <= 1'b0;
            state_r         <= ST_HI_WAIT;
          end
        end
        ST_HI_WAIT: begin
          if (bus_rsp_valid) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= bus_rsp_err ? {DATA_WIDTH{1'b0}} : merged_s;
            rsp_err_r   <= bus_rsp_err;
            rsp_split_r <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          bus_req_valid_r <= 1'b0;
          rsp_valid_r     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = (state_r == ST_IDLE) && !rst;
  assign bus_req_valid = bus_req_valid_r;
  assign bus_req_addr  = bus_req_addr_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_err       = rsp_err_r;
  assign rsp_split     = rsp_split_r;

endmodule

// File: tb/tb_load_split_merge.sv
// Randomized scoreboard bench for load_split_merge against a byte-memory model.
module tb_load_split_merge;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_sign;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_rsp_valid, bus_rsp_err;
  logic [63:0] bus_rsp_data;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_split;
  logic [63:0] rsp_data;

  logic        ns_req_valid, ns_req_ready, ns_req_sign;
  logic [31:0] ns_req_addr;
  logic [1:0]  ns_req_size;
  logic        ns_bus_req_valid, ns_bus_req_ready;
  logic [31:0] ns_bus_req_addr;
  logic        ns_bus_rsp_valid, ns_bus_rsp_err;
  logic [63:0] ns_bus_rsp_data;
  logic        ns_rsp_valid, ns_rsp_ready, ns_rsp_err, ns_rsp_split;
  logic [63:0] ns_rsp_data;

  load_split_merge #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .HAS_SIGN(1), .ALLOW_SPLIT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_split(rsp_split));

  load_split_merge #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .HAS_SIGN(1), .ALLOW_SPLIT(0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .req_addr(ns_req_addr), .req_size(ns_req_size), .req_sign(ns_req_sign),
    .bus_req_valid(ns_bus_req_valid), .bus_req_ready(ns_bus_req_ready), .bus_req_addr(ns_bus_req_addr),
    .bus_rsp_valid(ns_bus_rsp_valid), .bus_rsp_data(ns_bus_rsp_data), .bus_rsp_err(ns_bus_rsp_err),
    .rsp_valid(ns_rsp_valid), .rsp_ready(ns_rsp_ready), .rsp_data(ns_rsp_data),
    .rsp_err(ns_rsp_err), .rsp_split(ns_rsp_split));

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic        sp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_bus_q[$];
  logic [31:0] pend_addr[$];
  int          pend_delay[$];
  logic [7:0]  mem[logic [31:0]];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] err_addr = 32'h1;
  bit          zero_wait = 1'b0;
  bit          rsp_always = 1'b0;
  bit          hold_rsp = 1'b0;
  int          breq_hold = 0;
  int          rsp_hold = 0;
  bit          ns_bus_seen = 1'b0;
  int          lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 32'd2654435761) >> 24);
  endfunction

  function automatic logic [63:0] beat(input logic [31:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = rd(a + 32'(i));
    return v;
  endfunction

  task automatic set_beat(input logic [31:0] a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[a + 32'(i)] = v[8*i +: 8];
  endtask

  // Byte-level reference: gather nbytes from memory, extend, apply error rules
  task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ea, output exp_t x,
                       output logic [31:0] lo_a, output logic cr);
    int nb;
    int off;
    nb   = 1 << sz;
    off  = int'(a % 32'd8);
    cr   = (off + nb) > 8;
    lo_a = a & 32'hFFFF_FFF8;
    x.e  = (ea == lo_a) || (cr && (ea == lo_a + 32'd8));
    x.sp = cr && (ea != lo_a);
    x.d  = 64'd0;
    for (int i = 0; i < nb; i++) x.d[8*i +: 8] = rd(a + 32'(i));
    if (sg && nb < 8 && x.d[8*nb-1])
      for (int i = 8*nb; i < 64; i++) x.d[i] = 1'b1;
    if (x.e) x.d = 64'd0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ea, output int l);
    exp_t        x;
    logic [31:0] lo_a;
    logic        cr;
    int          n;
    err_addr = ea;
    model(a, sz, sg, ea, x, lo_a, cr);
    exp_q.push_back(x);
    exp_bus_q.push_back(lo_a);
    if (cr && ea != lo_a) exp_bus_q.push_back(lo_a + 32'd8);
    req_addr = a; req_size = sz; req_sign = sg; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) fail("req_accept");
    @(negedge clk);
    req_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 300) begin @(negedge clk); l++; end
    if (l >= 300) fail("rsp_wait");
    n = 0;
    while (rsp_valid && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) fail("rsp_drain");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bus_req_valid"}, 64'(bus_req_valid), 64'd0);
    chk({tag, "_bus_req_addr"}, 64'(bus_req_addr), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_rsp_split"}, 64'(rsp_split), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  // Bus slave: random ready, in-order responses with random latency
  initial begin
    bit          acc_pend = 1'b0;
    logic [31:0] acc_addr = 32'd0;
    bit          prev_v = 1'b0;
    bit          prev_acc = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 64'd0; bus_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (acc_pend) begin
        if (exp_bus_q.size() == 0) fail("bus_unexpected_req");
        else chk("bus_req_addr", 64'(acc_addr), 64'(exp_bus_q.pop_front()));
        pend_addr.push_back(acc_addr);
        pend_delay.push_back(zero_wait ? 0 : int'($urandom_range(0, 3)));
      end
      if (prev_v && !prev_acc && bus_req_valid)
        chk("bus_addr_stable", 64'(bus_req_addr), 64'(prev_addr));
      if (bus_req_valid && breq_hold > 0) begin
        bus_req_ready = 1'b0;
        breq_hold--;
      end else begin
        bus_req_ready = zero_wait ? 1'b1 : ($urandom_range(0, 9) < 7);
      end
      acc_pend  = bus_req_valid && bus_req_ready;
      acc_addr  = bus_req_addr;
      prev_v    = bus_req_valid;
      prev_acc  = acc_pend;
      prev_addr = bus_req_addr;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      if (pend_addr.size() > 0 && !hold_rsp) begin
        if (pend_delay[0] == 0) begin
          bus_rsp_valid = 1'b1;
          bus_rsp_data  = beat(pend_addr[0]);
          bus_rsp_err   = (pend_addr[0] == err_addr);
          void'(pend_addr.pop_front());
          void'(pend_delay.pop_front());
        end else begin
          pend_delay[0] = pend_delay[0] - 1;
        end
      end
    end
  end

  // Response monitor: scoreboard pop, output stability and handshake timing
  initial begin
    bit          prev_rv = 1'b0;
    bit          prev_rr = 1'b0;
    bit          prev_hs = 1'b0;
    logic [63:0] prev_d = 64'd0;
    logic        prev_e = 1'b0;
    logic        prev_s = 1'b0;
    exp_t        x;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ns_bus_req_valid) ns_bus_seen = 1'b1;
      if (prev_rv && !prev_rr && rsp_valid) begin
        chk("rsp_data_stable", rsp_data, prev_d);
        chk("rsp_err_stable", 64'(rsp_err), 64'(prev_e));
        chk("rsp_split_stable", 64'(rsp_split), 64'(prev_s));
      end
      if (prev_hs && !rst) chk("req_ready_after_rsp", 64'(req_ready), 64'd1);
      if (rsp_valid || bus_req_valid) chk("req_ready_busy", 64'(req_ready), 64'd0);
      if (rsp_valid && rsp_hold > 0) begin
        rsp_ready = 1'b0;
        rsp_hold--;
      end else begin
        rsp_ready = rsp_always ? 1'b1 : ($urandom_range(0, 9) < 6);
      end
      prev_hs = rsp_valid && rsp_ready;
      if (prev_hs) begin
        if (exp_q.size() == 0) fail("rsp_unexpected");
        else begin
          x = exp_q.pop_front();
          chk("rsp_data", rsp_data, x.d);
          chk("rsp_err", 64'(rsp_err), 64'(x.e));
          chk("rsp_split", 64'(rsp_split), 64'(x.sp));
        end
      end
      prev_rv = rsp_valid; prev_rr = rsp_ready;
      prev_d = rsp_data; prev_e = rsp_err; prev_s = rsp_split;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          n;
    bit          seen;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_sign = 1'b0;
    ns_req_valid = 1'b0; ns_req_addr = 32'd0; ns_req_size = 2'd0; ns_req_sign = 1'b0;
    ns_bus_req_ready = 1'b1; ns_bus_rsp_valid = 1'b0; ns_bus_rsp_data = 64'd0;
    ns_bus_rsp_err = 1'b0; ns_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);

    zero_wait = 1'b1; rsp_always = 1'b1;
    set_beat(32'h1000, 64'h0000_0000_8000_0000);
    issue(32'h1003, 2'd0, 1'b1, 32'h1, lat);
    chk("lat_aligned", 64'(lat), 64'd3);

    set_beat(32'h1000, 64'hAABB_0000_0000_0000);
    set_beat(32'h1008, 64'h0000_0000_0000_CCDD);
    issue(32'h1006, 2'd2, 1'b0, 32'h1, lat);
    chk("lat_split", 64'(lat), 64'd5);

    issue(32'h1007, 2'd1, 1'b1, 32'h1000, lat);
    issue(32'h1006, 2'd2, 1'b1, 32'h1008, lat);
    issue(32'hFFFF_FFFE, 2'd2, 1'b1, 32'h1, lat);

    breq_hold = 2; rsp_hold = 3;
    issue(32'h1010, 2'd3, 1'b0, 32'h1, lat);
    chk("lat_backpressure", 64'(lat), 64'd5);

    // No-split instance: crossing loads fail immediately without bus traffic
    @(negedge clk);
    ns_req_addr = 32'h1004; ns_req_size = 2'd3; ns_req_sign = 1'b0; ns_req_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!ns_req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      ns_req_valid = 1'b0;
      chk("ns_rsp_valid", 64'(ns_rsp_valid), 64'd1);
      chk("ns_rsp_err", 64'(ns_rsp_err), 64'd1);
      chk("ns_rsp_data", ns_rsp_data, 64'd0);
      chk("ns_rsp_split", 64'(ns_rsp_split), 64'd0);
      ns_rsp_ready = 1'b1;
      @(negedge clk);
      ns_rsp_ready = 1'b0;
      chk("ns_rsp_valid_drop", 64'(ns_rsp_valid), 64'd0);
      chk("ns_req_ready_again", 64'(ns_req_ready), 64'd1);
      ns_req_addr = 32'h1006; ns_req_size = 2'd2; ns_req_sign = 1'b1; ns_req_valid = 1'b1;
    end
    ns_req_valid = 1'b0;

    zero_wait = 1'b0; rsp_always = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ea;
      logic [1:0]  sz;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'h2000 + 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: ea = a & 32'hFFFF_FFF8;
        1: ea = (a & 32'hFFFF_FFF8) + 32'd8;
        default: ea = 32'h1;
      endcase
      issue(a, sz, 1'($urandom_range(0, 1)), ea, lat);
    end

    // Reset while waiting on the high beat; the late beat must be ignored
    zero_wait = 1'b1; rsp_always = 1'b1;
    issue_reset_case: begin
      req_addr = 32'h1006; req_size = 2'd2; req_sign = 1'b0; req_valid = 1'b1;
      err_addr = 32'h1;
      exp_bus_q.push_back(32'h1000);
      exp_bus_q.push_back(32'h1008);
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hold_rsp = 1'b1;
      @(posedge clk); #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset_hi_wait");
      @(posedge clk); #2 rst = 1'b0;
      hold_rsp = 1'b0;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      chk("stale_rsp_ignored", 64'(seen), 64'd0);
      chk("req_ready_after_reset", 64'(req_ready), 64'd1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("exp_bus_q_empty", 64'(exp_bus_q.size()), 64'd0);
    chk("ns_no_bus_req", 64'(ns_bus_seen), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
